// File: rtl/rip_csr_trap_unit.sv
// Machine-mode CSR responder (mtvec/mepc/mcause) and trap/MRET sequencer.
// Handles one request at a time and issues the fetch redirect for trap entry and MRET.
module rip_csr_trap_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_req_valid,
  output logic            csr_req_ready,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic            csr_rsp_valid,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  output logic            trap_ready,
  input  logic            mret_valid,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [11:0]     ADDR_MTVEC  = 12'h305;
  localparam logic [11:0]     ADDR_MEPC   = 12'h341;
  localparam logic [11:0]     ADDR_MCAUSE = 12'h342;
  localparam logic [XLEN-1:0] ALIGN_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {IDLE, CSR_RSP, TRAP_EPC, TRAP_CAUSE, REDIRECT} state_t;

  state_t          state;
  logic [XLEN-1:0] mtvec, mepc, mcause;
  logic [1:0]      op_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] wdata_q, trap_pc_q, trap_cause_q;
  logic [XLEN-1:0] rd_req, rd_q, wr_val;

  function automatic logic csr_hit(input logic [11:0] addr);
    return (addr == ADDR_MTVEC) || (addr == ADDR_MEPC) || (addr == ADDR_MCAUSE);
  endfunction

  function automatic logic [XLEN-1:0] csr_mux(input logic [11:0] addr,
                                               input logic [XLEN-1:0] tv,
                                               input logic [XLEN-1:0] ep,
                                               input logic [XLEN-1:0] mc);
    case (addr)
      ADDR_MTVEC:  return tv;
      ADDR_MEPC:   return ep;
      ADDR_MCAUSE: return mc;
      default:     return '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] csr_modify(input logic [1:0] op,
                                                  input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] wd);
    case (op)
      2'b01:   return wd;
      2'b10:   return old | wd;
      2'b11:   return old & ~wd;
      default: return old;
    endcase
  endfunction

  always_comb begin
    rd_req = csr_mux(csr_addr, mtvec, mepc, mcause);
    rd_q   = csr_mux(addr_q, mtvec, mepc, mcause);
    wr_val = csr_modify(op_q, rd_q, wdata_q);
  end

  // Trap beats MRET beats CSR; the losers see ready low in the same cycle.
  assign trap_ready    = (state == IDLE);
  assign csr_req_ready = (state == IDLE) && !trap_valid && !mret_valid;
  assign mtvec_o       = mtvec;
  assign mepc_o        = mepc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      mtvec          <= MTVEC_RESET & ALIGN_MASK;
      mepc           <= '0;
      mcause         <= '0;
      op_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      trap_pc_q      <= '0;
      trap_cause_q   <= '0;
      csr_rsp_valid  <= 1'b0;
      csr_rdata      <= '0;
      csr_illegal    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      csr_rsp_valid  <= 1'b0;
      csr_rdata      <= '0;
      csr_illegal    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      case (state)
        IDLE: begin
          if (trap_valid) begin
            trap_pc_q    <= trap_pc;
            trap_cause_q <= trap_cause;
            state        <= TRAP_EPC;
          end else if (mret_valid) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc;
            state          <= REDIRECT;
          end else if (csr_req_valid) begin
            op_q          <= csr_op;
            addr_q        <= csr_addr;
            wdata_q       <= csr_wdata;
            csr_rsp_valid <= 1'b1;
            csr_rdata     <= rd_req;
            csr_illegal   <= !csr_hit(csr_addr);
            state         <= CSR_RSP;
          end
        end
        // Response is on the outputs this cycle; the write lands at its end.
        CSR_RSP: begin
          if (op_q != 2'b00) begin
            case (addr_q)
              ADDR_MTVEC:  mtvec  <= wr_val & ALIGN_MASK;
              ADDR_MEPC:   mepc   <= wr_val & ALIGN_MASK;
              ADDR_MCAUSE: mcause <= wr_val;
              default: ;
            endcase
          end
          state <= IDLE;
        end
        TRAP_EPC: begin
          mepc  <= trap_pc_q & ALIGN_MASK;
          state <= TRAP_CAUSE;
        end
        TRAP_CAUSE: begin
          mcause         <= trap_cause_q;
          redirect_valid <= 1'b1;
          redirect_pc    <= mtvec;
          state          <= REDIRECT;
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rip_csr_trap_unit.sv
// Bench for rip_csr_trap_unit: directed vector table, hand-written trap/MRET/reset
// sequences, then random traffic checked against a register-level model.
module tb_rip_csr_trap_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1003;

  logic        clk = 0;
  logic        rst;
  logic        csr_req_valid, csr_req_ready;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_rsp_valid;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_valid;
  logic [31:0] trap_cause, trap_pc;
  logic        trap_ready;
  logic        mret_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc, mtvec_o, mepc_o;

  rip_csr_trap_unit #(.XLEN(32), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst(rst),
    .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rsp_valid(csr_rsp_valid), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_ready(trap_ready), .mret_valid(mret_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_mtvec, m_mepc, m_mcause;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic m_hit(input logic [11:0] a);
    return a == 12'h305 || a == 12'h341 || a == 12'h342;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (a == 12'h305) return m_mtvec;
    if (a == 12'h341) return m_mepc;
    if (a == 12'h342) return m_mcause;
    return 32'h0;
  endfunction

  task automatic m_apply(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] old, nv;
    old = m_read(a);
    if (op == 2'd1) nv = wd;
    else if (op == 2'd2) nv = old | wd;
    else if (op == 2'd3) nv = old & ~wd;
    else nv = old;
    if (a == 12'h305) m_mtvec = {nv[31:2], 2'b00};
    else if (a == 12'h341) m_mepc = {nv[31:2], 2'b00};
    else if (a == 12'h342) m_mcause = nv;
  endtask

  // One CSR transaction; returns the response seen one cycle after the accept edge.
  task automatic csr_txn(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic ill);
    bit got = 0;
    csr_req_valid = 1; csr_op = op; csr_addr = a; csr_wdata = wd;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (csr_req_ready) begin got = 1; break; end
      step();
    end
    chk("csr_ready_timeout", {31'b0, got}, 32'd1);
    step();
    csr_req_valid = 0;
    chk("csr_rsp_valid", {31'b0, csr_rsp_valid}, 32'd1);
    rd = csr_rdata; ill = csr_illegal;
    step();
    chk("csr_rsp_single", {31'b0, csr_rsp_valid}, 32'd0);
  endtask

  // Waits for the redirect after the accept edge already taken; checks latency, target, width.
  task automatic expect_redirect(input int lat, input logic [31:0] pc, input string tag);
    int k = 0;
    for (int n = 1; n <= 8; n++) begin
      if (redirect_valid) begin k = n; break; end
      step();
    end
    chk({tag, "_latency"}, k, lat);
    chk({tag, "_pc"}, redirect_pc, pc);
    step();
    chk({tag, "_single"}, {31'b0, redirect_valid}, 32'd0);
  endtask

  task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc);
    bit got = 0;
    trap_valid = 1; trap_cause = cause; trap_pc = pc;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (trap_ready) begin got = 1; break; end
      step();
    end
    chk("trap_ready_timeout", {31'b0, got}, 32'd1);
    step();
    trap_valid = 0;
    m_mepc = {pc[31:2], 2'b00};
    m_mcause = cause;
    expect_redirect(3, m_mtvec, "trap_redir");
    chk("trap_mepc", mepc_o, m_mepc);
  endtask

  task automatic do_mret();
    mret_valid = 1;
    step();
    mret_valid = 0;
    expect_redirect(1, m_mepc, "mret_redir");
  endtask

  initial begin
    logic [31:0] rd;
    logic        ill;
    rst = 1; csr_req_valid = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
    trap_valid = 0; trap_cause = 0; trap_pc = 0; mret_valid = 0;
    m_mtvec = 32'h1000; m_mepc = 0; m_mcause = 0;

    vecs[0]  = '{2'd0, 12'h305, 32'h0,         32'h0000_1000, 1'b0};
    vecs[1]  = '{2'd1, 12'h305, 32'h8000_0103, 32'h0000_1000, 1'b0};
    vecs[2]  = '{2'd0, 12'h305, 32'h0,         32'h8000_0100, 1'b0};
    vecs[3]  = '{2'd1, 12'h342, 32'h0F,        32'h0,         1'b0};
    vecs[4]  = '{2'd2, 12'h342, 32'hF0,        32'h0F,        1'b0};
    vecs[5]  = '{2'd3, 12'h342, 32'h03,        32'hFF,        1'b0};
    vecs[6]  = '{2'd0, 12'h342, 32'h0,         32'hFC,        1'b0};
    vecs[7]  = '{2'd0, 12'h7C0, 32'h0,         32'h0,         1'b1};
    vecs[8]  = '{2'd1, 12'h7C0, 32'hFFFF,      32'h0,         1'b1};
    vecs[9]  = '{2'd0, 12'h342, 32'h0,         32'hFC,        1'b0};
    vecs[10] = '{2'd1, 12'h341, 32'h1237,      32'h0,         1'b0};
    vecs[11] = '{2'd0, 12'h341, 32'h0,         32'h1234,      1'b0};
    vecs[12] = '{2'd1, 12'h305, 32'h100,       32'h8000_0100, 1'b0};
    vecs[13] = '{2'd0, 12'h305, 32'h0,         32'h100,       1'b0};

    #12;
    chk("rst_rsp_valid", {31'b0, csr_rsp_valid}, 32'd0);
    chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
    chk("rst_rdata", csr_rdata, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_mtvec", mtvec_o, 32'h1000);
    chk("rst_mepc", mepc_o, 32'd0);
    step();
    rst = 0;
    step();

    foreach (vecs[i]) begin
      csr_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, ill);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_illegal", i), {31'b0, ill}, {31'b0, vecs[i].exp_ill});
    end
    chk("vec_mtvec_o", mtvec_o, 32'h100);
    m_mtvec = 32'h100; m_mepc = 32'h1234; m_mcause = 32'hFC;

    // Illegal-instruction trap
    do_trap(32'd2, 32'h1236);
    chk("trap2_mepc", mepc_o, 32'h1234);
    csr_txn(2'd0, 12'h342, 32'h0, rd, ill);
    chk("trap2_mcause", rd, 32'd2);

    // Trap, MRET and CSR all in the same cycle: only the trap is taken
    trap_valid = 1; trap_cause = 32'd11; trap_pc = 32'h2000;
    mret_valid = 1;
    csr_req_valid = 1; csr_op = 2'd0; csr_addr = 12'h342; csr_wdata = 0;
    #1;
    chk("prio_trap_ready", {31'b0, trap_ready}, 32'd1);
    chk("prio_csr_ready", {31'b0, csr_req_ready}, 32'd0);
    step();
    trap_valid = 0; mret_valid = 0;
    chk("prio_no_csr_rsp", {31'b0, csr_rsp_valid}, 32'd0);
    m_mepc = 32'h2000; m_mcause = 32'd11;
    expect_redirect(3, 32'h100, "prio_redir");
    csr_txn(2'd0, 12'h342, 32'h0, rd, ill);
    chk("prio_csr_mcause", rd, 32'd11);
    do_mret();

    // Reset while in TRAP_CAUSE
    trap_valid = 1; trap_cause = 32'd2; trap_pc = 32'h5554;
    #1;
    step();
    trap_valid = 0;
    step();
    #1 rst = 1;
    #1;
    chk("midrst_redirect", {31'b0, redirect_valid}, 32'd0);
    chk("midrst_mtvec", mtvec_o, 32'h1000);
    chk("midrst_mepc", mepc_o, 32'd0);
    step();
    rst = 0;
    m_mtvec = 32'h1000; m_mepc = 0; m_mcause = 0;
    begin
      int seen = 0;
      for (int n = 0; n < 5; n++) begin
        if (redirect_valid) seen++;
        step();
      end
      chk("midrst_no_redirect", seen, 0);
    end
    csr_txn(2'd0, 12'h342, 32'h0, rd, ill);
    chk("midrst_mcause", rd, 32'd0);
    do_trap(32'd11, 32'h0000_4444);

    // Random traffic against the model
    for (int it = 0; it < 300; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        logic [1:0]  op;
        logic [11:0] a;
        logic [31:0] wd, exp_rd;
        logic        exp_ill;
        int ac;
        op = 2'($urandom_range(0, 3));
        ac = $urandom_range(0, 4);
        a = (ac == 0) ? 12'h305 : (ac == 1) ? 12'h341 : (ac == 2) ? 12'h342 :
            (ac == 3) ? 12'h7C0 : 12'($urandom);
        wd = $urandom;
        exp_rd = m_read(a);
        exp_ill = !m_hit(a);
        csr_txn(op, a, wd, rd, ill);
        chk("rnd_rdata", rd, exp_rd);
        chk("rnd_illegal", {31'b0, ill}, {31'b0, exp_ill});
        m_apply(op, a, wd);
        chk("rnd_mtvec_o", mtvec_o, m_mtvec);
        chk("rnd_mepc_o", mepc_o, m_mepc);
      end else if (sel < 8) begin
        logic [31:0] c, p;
        c = ($urandom_range(0, 1) == 0) ? 32'd2 : 32'd11;
        p = $urandom;
        do_trap(c, p);
      end else begin
        do_mret();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rip_csr_trap_unit.md
Name: rip_csr_trap_unit

Overview:
- Machine-mode CSR responder and trap sequencer for the RIP core.
- Owns the MTVEC (0x305), MEPC (0x341) and MCAUSE (0x342) registers.
- Serves CSR read/modify/write requests from the execute stage.
- Records trap entry for illegal instruction (cause 2) and ECALL (cause 11).
- Issues the PC redirect for both trap entry and MRET back to the fetch stage.

Parameters:
- XLEN, 32, register and data width.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] are ignored and forced to 0.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- csr_req_valid  in  1  CSR request from execute.
- csr_req_ready  out  1  unit can accept a CSR request this cycle.
- csr_op  in  2  00 read-only, 01 RW, 10 RS (set bits), 11 RC (clear bits).
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  operand (rs1 or zimm, zero-extended).
- csr_rsp_valid  out  1  one-cycle response strobe.
- csr_rdata  out  XLEN  old CSR value.
- csr_illegal  out  1  address not implemented; qualified by csr_rsp_valid.
- trap_valid  in  1  trap request.
- trap_cause  in  XLEN  cause code.
- trap_pc  in  XLEN  PC of the faulting instruction.
- trap_ready  out  1  trap accepted this cycle.
- mret_valid  in  1  MRET retired; single-cycle pulse.
- redirect_valid  out  1  one-cycle fetch redirect strobe.
- redirect_pc  out  XLEN  redirect target.
- mtvec_o, mepc_o  out  XLEN  current register values, for debug and fetch.

Behaviour:
- Reset (asynchronous): state IDLE; mtvec = MTVEC_RESET & ~3; mepc = 0; mcause = 0. All strobes, csr_rdata and redirect_pc are 0. Reset mid-sequence abandons the sequence with no redirect and no further register writes.
- FSM states: IDLE, CSR_RSP, TRAP_EPC, TRAP_CAUSE, REDIRECT.
- Ready signals: csr_req_ready and trap_ready are high only in IDLE, and only one handshake completes per cycle.
- Priority in IDLE: trap_valid > mret_valid > csr_req_valid. When a higher-priority request wins, the lower-priority ready is 0 that cycle.
- CSR path:
  - IDLE accepts the request and captures op, address and data; next state is CSR_RSP.
  - CSR_RSP: csr_rsp_valid = 1 for exactly 1 cycle (response latency 1 cycle); csr_rdata = pre-write value; the write commits at the end of the same cycle; return to IDLE. Back-to-back accepts are therefore spaced at 2 cycles.
  - Write value: RW writes wdata; RS writes old | wdata; RC writes old & ~wdata; op 00 performs no write.
  - Write masks: mtvec and mepc bits [1:0] are forced to 0 (direct mode only); mcause is fully writable.
  - Unimplemented address: csr_illegal = 1, csr_rdata = 0, no state change.
- Trap path:
  - Acceptance in IDLE captures trap_pc and trap_cause.
  - TRAP_EPC writes mepc = trap_pc & ~3.
  - TRAP_CAUSE writes mcause = trap_cause.
  - REDIRECT: redirect_valid = 1 with redirect_pc = mtvec. redirect_valid rises 3 cycles after the accept edge; then return to IDLE.
- MRET: accepted in IDLE (no ready signal; always taken unless a trap is present the same cycle; an MRET lost to a trap is dropped). Next state is REDIRECT with redirect_pc = mepc.
- Inputs while not IDLE: trap_valid is held by the requester until trap_ready; csr_req_valid is held until ready; mret_valid is not held and must not be issued while not IDLE (protocol error, ignored).
- Trap while a CSR write is in CSR_RSP: the trap waits; it observes the committed CSR value.

Test Plan:
- Reset then CSR read 0x305, op 00 → 1 cycle later rsp_valid = 1, rdata = MTVEC_RESET, illegal = 0.
- CSRRW 0x305 wdata 0x8000_0103 → rdata = old value; then read mtvec = 0x8000_0100.
- CSRRS 0x342 with 0xF0 after mcause = 0x0F, then CSRRC 0x342 with 0x03 → mcause = 0xFC. CSR read 0x7C0 → illegal = 1, rdata = 0, no register changes.
- mtvec = 0x100; trap cause 2, pc 0x1236 → mepc = 0x1234, mcause = 2, redirect_valid 3 cycles after accept with pc 0x100; one pulse only.
- Same cycle trap (cause 11) + csr_req_valid + mret_valid → only trap_ready = 1. CSR accepted after return to IDLE and reads mcause = 11. MRET → redirect_pc = mepc one cycle after accept.
- Assert rst in TRAP_CAUSE → no redirect, all registers at reset values, state IDLE; a trap issued after reset release completes normally.
